// File: rtl/camino_datos.sv
`default_nettype none
// camino_datos -- radix-2 Booth signed multiplier datapath: A/Q/M registers, status bits, product.
// Revision 1.0

module camino_datos #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CargaQ,
  input  logic           DesplazaAQ,
  input  logic           ResetA,
  input  logic           CargaA,
  input  logic           CargaM,
  input  logic           Fin,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           q0,
  output logic           qsub1,
  output logic [2*N-1:0] producto,
  output logic           listo,
  output logic           error
);

  // A carries one extra bit so A - M cannot overflow for M = -2^(N-1)
  logic [N:0]   acc;
  logic [N-1:0] q;
  logic [N-1:0] m;
  logic [N:0]   m_ext;
  logic         illegal;

  assign m_ext   = {m[N-1], m};
  assign q0      = q[0];
  assign illegal = CargaA & DesplazaAQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      qsub1    <= 1'b0;
      producto <= '0;
      listo    <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (CargaM)
        m <= multiplicando;

      if (ResetA) begin
        acc <= '0;
      end else if (CargaA) begin
        case ({q[0], qsub1})
          2'b01:   acc <= acc + m_ext;
          2'b10:   acc <= acc - m_ext;
          default: acc <= acc;
        endcase
      end else if (DesplazaAQ) begin
        acc <= {acc[N], acc[N:1]};
      end

      // an illegal add+shift drops the shift, so Q only moves on a clean shift
      if (CargaQ) begin
        q     <= multiplicador;
        qsub1 <= 1'b0;
      end else if (DesplazaAQ && !CargaA) begin
        q     <= {acc[0], q[N-1:1]};
        qsub1 <= q[0];
      end

      if (illegal)
        error <= 1'b1;

      if (Fin) begin
        producto <= {acc[N-1:0], q};
        listo    <= 1'b1;
      end else begin
        listo    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camino_datos.sv
`default_nettype none
// tb_camino_datos -- directed Booth sequences checked against an arithmetic product model.
// Revision 1.0

module tb_camino_datos;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           CargaQ, DesplazaAQ, ResetA, CargaA, CargaM, Fin;
  logic [N-1:0]   multiplicando, multiplicador;
  logic           q0, qsub1, listo, error;
  logic [2*N-1:0] producto;

  always #5 clk = ~clk;

  camino_datos #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .CargaQ(CargaQ), .DesplazaAQ(DesplazaAQ), .ResetA(ResetA),
    .CargaA(CargaA), .CargaM(CargaM), .Fin(Fin),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .q0(q0), .qsub1(qsub1), .producto(producto), .listo(listo), .error(error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: operands as integers, shift count k, product by plain multiplication.
  // After k clean shifts the Booth window {q0,qsub1} sits on multiplier bits k and k-1.
  int             k, mc, ml;
  logic [2*N-1:0] e_prod;
  logic           e_listo, e_err, prod_ok, chk;
  int             pr;

  initial chk = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      k = 0; mc = 0; ml = 0; e_prod = '0; e_listo = 1'b0; e_err = 1'b0; prod_ok = 1'b1;
    end else begin
      if (CargaA && DesplazaAQ) begin
        e_err   = 1'b1;
        prod_ok = 1'b0;
      end
      if (Fin) begin
        if (k != N) prod_ok = 1'b0;
        pr     = mc * ml;
        e_prod = pr[2*N-1:0];
      end
      e_listo = Fin;
      if (CargaM) mc = int'($signed(multiplicando));
      if (CargaQ) begin
        ml = int'($signed(multiplicador));
        k  = 0;
      end else if (DesplazaAQ && !CargaA) begin
        k++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("listo", 16'(listo), 16'(e_listo));
      check("error", 16'(error), 16'(e_err));
      if (prod_ok) check("producto", 16'(producto), 16'(e_prod));
      if (k < N) check("q0", 16'(q0), 16'(ml[k]));
      if (k == 0) check("qsub1", 16'(qsub1), 16'd0);
      else if (k <= N) check("qsub1", 16'(qsub1), 16'(ml[k-1]));
    end
  end

  logic [1:0] seen [3];

  task automatic cyc(input logic cq, da, ra, ca, cm, fn);
    {CargaQ, DesplazaAQ, ResetA, CargaA, CargaM, Fin} = {cq, da, ra, ca, cm, fn};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input logic [N-1:0] a, b, input bit disturb, input int finhold,
                     input logic [2*N-1:0] exp_lit);
    multiplicando = a;
    multiplicador = b;
    cyc(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      if (disturb) begin multiplicando = N'($urandom); multiplicador = N'($urandom); end
      seen[i] = {q0, qsub1};
      cyc(0, 0, 0, 1, 0, 0);
      if (disturb) begin multiplicando = N'($urandom); multiplicador = N'($urandom); end
      cyc(0, 1, 0, 0, 0, 0);
    end
    for (int f = 0; f < finhold; f++) begin
      cyc(0, 0, 0, 0, 0, 1);
      check("listo_lit", 16'(listo), 16'd1);
      check("producto_lit", 16'(producto), 16'(exp_lit));
    end
    idle();
    check("producto_hold", 16'(producto), 16'(exp_lit));
  endtask

  initial begin
    reset = 1'b1;
    multiplicando = '0;
    multiplicador = '0;
    idle();
    idle();
    chk = 1'b1;
    check("reset_prod", 16'(producto), 16'd0);
    check("reset_q0", 16'(q0), 16'd0);
    check("reset_err", 16'(error), 16'd0);
    reset = 1'b0;

    // 3 x 2 straight from reset release: product after 8 edges
    run(3'd3, 3'd2, 1'b0, 1, 6'b000110);
    check("win_s1", 16'(seen[0]), 16'b00);
    check("win_s3", 16'(seen[1]), 16'b10);
    check("win_s5", 16'(seen[2]), 16'b01);

    run(3'b100, 3'b100, 1'b0, 1, 6'b010000);
    check("err_after_m4", 16'(error), 16'd0);
    run(3'b101, 3'd3, 1'b0, 1, 6'b110111);
    run(3'd0, 3'b111, 1'b0, 1, 6'b000000);

    // reset in the S3 slot, then a clean 2 x -2
    multiplicando = 3'd3;
    multiplicador = 3'd2;
    cyc(1, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    check("mid_reset_prod", 16'(producto), 16'd0);
    check("mid_reset_q0", 16'(q0), 16'd0);
    check("mid_reset_qsub1", 16'(qsub1), 16'd0);
    check("mid_reset_listo", 16'(listo), 16'd0);
    run(3'd2, 3'b110, 1'b0, 1, 6'b111100);

    // operands wander after the load; Fin held for 3 cycles
    run(3'b101, 3'd2, 1'b1, 3, 6'b111010);

    // illegal add+shift with window 01, M=1, A=0
    multiplicando = 3'd1;
    multiplicador = 3'd1;
    cyc(1, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("ill_window", 16'({q0, qsub1}), 16'b01);
    cyc(0, 1, 0, 1, 0, 0);
    check("ill_err", 16'(error), 16'd1);
    check("ill_q_hold", 16'({q0, qsub1}), 16'b01);
    cyc(0, 0, 0, 0, 0, 1);
    check("ill_prod", 16'(producto), 16'(6'b001000));
    repeat (3) idle();
    check("ill_err_sticky", 16'(error), 16'd1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("ill_err_cleared", 16'(error), 16'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
